// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared funct3 codes, FSM encoding and B-immediate rebuild
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The decoder hands the B immediate over split exactly as it sits in the instruction word.
  function automatic logic [12:0] build_imm_b(input logic [6:0] msb, input logic [4:0] lsb);
    return {msb[6], lsb[0], msb[5:0], lsb[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// rtl/branch_resolve_unit_cmp.sv - combinational branch condition evaluator (module branch_cmp)
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            cond,
  output logic            illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = (rs1 == rs2);
      F3_BNE:  cond = (rs1 != rs2);
      F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: cond = (rs1 <  rs2);
      F3_BGEU: cond = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves B-type branches and returns redirect info to fetch
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc,
  input  logic [2:0]       funct3,
  input  logic [6:0]       imm_B_MSB,
  input  logic [4:0]       imm_B_LSB,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target_pc,
  output logic             illegal,
  output logic             misaligned,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, rs1_q, rs2_q;
  logic [2:0]      f3_q;
  logic [6:0]      msb_q;
  logic [4:0]      lsb_q;

  logic            cond, cond_illegal;
  logic [12:0]     imm;
  logic [XLEN-1:0] imm_sext, target_d;
  logic            taken_d, misaligned_d, handshake;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1     (rs1_q),
    .rs2     (rs2_q),
    .funct3  (f3_q),
    .cond    (cond),
    .illegal (cond_illegal)
  );

  assign imm          = build_imm_b(msb_q, lsb_q);
  assign imm_sext     = {{(XLEN-13){imm[12]}}, imm};
  assign taken_d      = cond & ~cond_illegal;
  assign target_d     = taken_d ? (pc_q + imm_sext) : (pc_q + PC_STEP);
  assign misaligned_d = taken_d & (target_d[1:0] != 2'b00);

  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign handshake = res_valid & res_ready;
  // Only a legal, aligned, taken branch redirects fetch.
  assign flush     = handshake & taken & ~misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EVAL;
      ST_EVAL: state_d = ST_RESP;
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      f3_q  <= '0;
      msb_q <= '0;
      lsb_q <= '0;
    end else if (state_q == ST_IDLE && in_valid) begin
      pc_q  <= pc;
      rs1_q <= rs1_data;
      rs2_q <= rs2_data;
      f3_q  <= funct3;
      msb_q <= imm_B_MSB;
      lsb_q <= imm_B_LSB;
    end
  end

  // Result registers stay put through RESP so the consumer sees stable fields under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken      <= 1'b0;
      target_pc  <= '0;
      illegal    <= 1'b0;
      misaligned <= 1'b0;
    end else if (state_q == ST_EVAL) begin
      taken      <= taken_d;
      target_pc  <= target_d;
      illegal    <= cond_illegal;
      misaligned <= misaligned_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (handshake) begin
      if (branch_count != CNT_MAX) branch_count <= branch_count + CNT_ONE;
      if (flush && taken_count != CNT_MAX) taken_count <= taken_count + CNT_ONE;
    end
  end

endmodule
